// File: rtl/layer_sequencer_if.sv
// Config-table read port and accelerator start/done handshake
// shared by the layer sequencer and its neighbours.
interface layer_sequencer_if #(
  parameter int CFG_WIDTH = 64
);
  logic                 cfg_rd_en;
  logic [3:0]           cfg_addr;
  logic [CFG_WIDTH-1:0] cfg_data;
  logic                 start;
  logic                 done;

  modport master (
    output cfg_rd_en, cfg_addr, start,
    input  cfg_data, done
  );

  modport slave (
    input  cfg_rd_en, cfg_addr, start,
    output cfg_data, done
  );
endinterface

// File: rtl/layer_sequencer.sv
// Walks a network layer by layer: fetches each config word, validates it,
// launches the accelerator and chains output buffers into the next input.
module layer_sequencer #(
  parameter int NUM_LAYERS   = 10,
  parameter int OFM_RAM_SIZE = 2378675,
  parameter int CFG_WIDTH    = 64,
  localparam int AW          = $clog2(OFM_RAM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          abort,
  layer_sequencer_if.master bus,
  output logic [3:0]    count_layer,
  output logic [8:0]    ifm_size,
  output logic [10:0]   ifm_channel,
  output logic [1:0]    kernel_size,
  output logic [10:0]   num_filter,
  output logic          maxpool_mode,
  output logic [1:0]    maxpool_stride,
  output logic          upsample_mode,
  output logic [AW-1:0] start_read_addr,
  output logic [AW-1:0] start_write_addr,
  output logic          busy,
  output logic          all_done,
  output logic          err,
  output logic [3:0]    err_layer,
  output logic [31:0]   layer_cycles
);

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, CHECK, START,
    WAIT, NEXT, FINISH, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        abort_q;
  logic        abort_any;
  logic        cfg_ok;
  logic        last;
  logic        rd_en;
  logic        start_p;
  logic [31:0] cyc_cnt;
  logic        unused_rsvd;

  assign abort_any = abort | abort_q;
  assign last      = (count_layer == 4'(NUM_LAYERS));

  assign cfg_ok =
    ((kernel_size == 2'd1) || (kernel_size == 2'd3)) &&
    (ifm_size >= {7'd0, kernel_size}) &&
    (ifm_channel != '0) &&
    (num_filter != '0) &&
    (!maxpool_mode ||
     (maxpool_stride == 2'd1) || (maxpool_stride == 2'd2));

  assign bus.cfg_rd_en = rd_en;
  assign bus.start     = start_p;
  assign bus.cfg_addr  = (state_q == FETCH) ? count_layer - 4'd1 : '0;
  assign unused_rsvd   = ^bus.cfg_data[CFG_WIDTH-1:37+AW];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    start_p  = 1'b0;
    all_done = 1'b0;
    busy     = (state_q != IDLE);
    unique case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH: begin
        rd_en   = 1'b1;
        state_d = abort_any ? FINISH : LATCH;
      end
      LATCH:  state_d = abort_any ? FINISH : CHECK;
      CHECK: begin
        if (abort_any)   state_d = FINISH;
        else if (cfg_ok) state_d = START;
        else             state_d = ERROR;
      end
      START: begin
        start_p = 1'b1;
        state_d = WAIT;
      end
      WAIT:   if (bus.done) state_d = NEXT;
      NEXT:   state_d = (last || abort_any) ? FINISH : FETCH;
      FINISH: begin
        all_done = 1'b1;
        state_d  = IDLE;
      end
      ERROR:  if (run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q          <= 1'b0;
      count_layer      <= '0;
      ifm_size         <= '0;
      ifm_channel      <= '0;
      kernel_size      <= '0;
      num_filter       <= '0;
      maxpool_mode     <= 1'b0;
      maxpool_stride   <= '0;
      upsample_mode    <= 1'b0;
      start_read_addr  <= '0;
      start_write_addr <= '0;
      err              <= 1'b0;
      err_layer        <= '0;
      layer_cycles     <= '0;
      cyc_cnt          <= '0;
    end else begin
      // Abort only arms during a run and never survives into IDLE.
      if (state_q == IDLE || state_d == IDLE) abort_q <= 1'b0;
      else if (abort)                         abort_q <= 1'b1;

      unique case (state_q)
        IDLE: if (run) begin
          count_layer     <= 4'd1;
          start_read_addr <= '0;
          err             <= 1'b0;
        end
        LATCH: begin
          ifm_size         <= bus.cfg_data[8:0];
          ifm_channel      <= bus.cfg_data[19:9];
          kernel_size      <= bus.cfg_data[21:20];
          num_filter       <= bus.cfg_data[32:22];
          maxpool_mode     <= bus.cfg_data[33];
          maxpool_stride   <= bus.cfg_data[35:34];
          upsample_mode    <= bus.cfg_data[36];
          start_write_addr <= bus.cfg_data[37 +: AW];
        end
        CHECK: if (!abort_any && !cfg_ok) begin
          err       <= 1'b1;
          err_layer <= count_layer;
        end
        START: cyc_cnt <= '0;
        WAIT:  if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
        NEXT: begin
          layer_cycles    <= cyc_cnt;
          start_read_addr <= start_write_addr;
          if (state_d == FETCH) count_layer <= count_layer + 4'd1;
        end
        ERROR: if (run) err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: 3-layer table, fixed-latency
// accelerator responder, error, abort, held-done and reset scenarios.
module tb_layer_sequencer;

  localparam int NL   = 3;
  localparam int AW   = 22;
  localparam int DLAT = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    count_layer;
  logic [8:0]    ifm_size;
  logic [10:0]   ifm_channel;
  logic [1:0]    kernel_size;
  logic [10:0]   num_filter;
  logic          maxpool_mode;
  logic [1:0]    maxpool_stride;
  logic          upsample_mode;
  logic [AW-1:0] start_read_addr;
  logic [AW-1:0] start_write_addr;
  logic          busy, all_done, err;
  logic [3:0]    err_layer;
  logic [31:0]   layer_cycles;

  layer_sequencer_if #(.CFG_WIDTH(64)) bus();

  layer_sequencer #(.NUM_LAYERS(NL)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .bus(bus),
    .count_layer(count_layer), .ifm_size(ifm_size),
    .ifm_channel(ifm_channel), .kernel_size(kernel_size),
    .num_filter(num_filter), .maxpool_mode(maxpool_mode),
    .maxpool_stride(maxpool_stride), .upsample_mode(upsample_mode),
    .start_read_addr(start_read_addr),
    .start_write_addr(start_write_addr),
    .busy(busy), .all_done(all_done), .err(err),
    .err_layer(err_layer), .layer_cycles(layer_cycles)
  );

  always #5 clk = ~clk;

  logic [63:0]   tbl [16];
  logic          done_hold = 1'b0;
  int            dcnt = 0;
  int            cyc_no = 0;
  int            n_start = 0, n_rd = 0, n_ad = 0;
  int            done_cyc = 0, ad_cyc = 0;
  logic [3:0]    lay_log [64];
  logic [AW-1:0] ra_log [64];
  int            n_chk = 0, n_fail = 0;

  assign bus.done = done_hold | (dcnt == DLAT);

  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (bus.cfg_rd_en) bus.cfg_data <= tbl[bus.cfg_addr];
    if (bus.start) dcnt <= 1;
    else if (dcnt != 0 && dcnt != DLAT) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (bus.start) begin
      lay_log[n_start] <= count_layer;
      ra_log[n_start]  <= start_read_addr;
      n_start <= n_start + 1;
    end
    if (bus.cfg_rd_en) n_rd <= n_rd + 1;
    if (all_done) begin
      n_ad   <= n_ad + 1;
      ad_cyc <= cyc_no;
    end
    if (bus.done && !done_hold) done_cyc <= cyc_no;
  end

  function automatic logic [63:0] mk(
    input int ifm, input int ch, input int k, input int nf,
    input int mp, input int ms, input int up, input int wa);
    logic [63:0] w;
    w        = '0;
    w[8:0]   = 9'(ifm);
    w[19:9]  = 11'(ch);
    w[21:20] = 2'(k);
    w[32:22] = 11'(nf);
    w[33]    = 1'(mp);
    w[35:34] = 2'(ms);
    w[36]    = 1'(up);
    w[58:37] = 22'(wa);
    w[63:59] = 5'h1f;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ad(input int target, input string tag);
    int k = 0;
    while (n_ad < target && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(n_ad >= target), 1);
  endtask

  task automatic wait_st(input int target, input string tag);
    int k = 0;
    while (n_start < target && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(n_start >= target), 1);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    cyc(1);
    run = 1'b0;
  endtask

  int b, r, a, k;

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tbl[0] = mk(13, 3, 3, 16, 1, 2, 0, 'h1000);
    tbl[1] = mk(26, 16, 1, 32, 0, 0, 1, 'h2000);
    tbl[2] = mk(52, 32, 3, 8, 1, 1, 0, 'h3000);

    cyc(1);
    rst = 1'b1;
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_layer", count_layer, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_rd", bus.cfg_rd_en, 0);
    chk("rst_addr", bus.cfg_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_cycles", layer_cycles, 0);
    chk("rst_waddr", start_write_addr, 0);
    rst = 1'b0;
    cyc(2);

    // Normal 3-layer run with latency checks
    b = n_start; r = n_rd; a = n_ad;
    run = 1'b1;
    cyc(1);
    run = 1'b0;
    chk("lat_rd", bus.cfg_rd_en, 1);
    chk("lat_addr", bus.cfg_addr, 0);
    chk("lat_layer", count_layer, 1);
    chk("lat_busy", busy, 1);
    cyc(1);
    chk("lat_rd_once", bus.cfg_rd_en, 0);
    cyc(2);
    chk("lat_start", bus.start, 1);
    wait_ad(a + 1, "run_tmo");
    chk("run_starts", n_start - b, 3);
    chk("run_rds", n_rd - r, 3);
    chk("run_lay1", lay_log[b], 1);
    chk("run_lay2", lay_log[b+1], 2);
    chk("run_lay3", lay_log[b+2], 3);
    chk("run_ra1", ra_log[b], 0);
    chk("run_ra2", ra_log[b+1], 'h1000);
    chk("run_ra3", ra_log[b+2], 'h2000);
    chk("run_cycles", layer_cycles, DLAT);
    chk("run_ad_lat", ad_cyc - done_cyc, 2);
    chk("run_idle", busy, 0);
    chk("cfg_ifm", ifm_size, 52);
    chk("cfg_ch", ifm_channel, 32);
    chk("cfg_k", kernel_size, 3);
    chk("cfg_nf", num_filter, 8);
    chk("cfg_mp", maxpool_mode, 1);
    chk("cfg_ms", maxpool_stride, 1);
    chk("cfg_up", upsample_mode, 0);
    chk("cfg_wa", start_write_addr, 'h3000);
    cyc(4);
    chk("run_one_ad", n_ad - a, 1);

    // Invalid kernel size on layer 2
    tbl[1] = mk(26, 16, 2, 32, 0, 0, 1, 'h2000);
    b = n_start; r = n_rd;
    pulse_run();
    k = 0;
    while (!err && k < 300) begin
      cyc(1);
      k++;
    end
    chk("err_flag", err, 1);
    chk("err_layer", err_layer, 2);
    cyc(5);
    chk("err_busy", busy, 1);
    chk("err_starts", n_start - b, 1);
    chk("err_rds", n_rd - r, 2);
    pulse_run();
    chk("err_clr", err, 0);
    chk("err_idle", busy, 0);
    cyc(2);
    chk("err_stay_idle", busy, 0);
    tbl[1] = mk(26, 16, 1, 32, 0, 0, 1, 'h2000);

    // Abort mid-WAIT of layer 1
    b = n_start; r = n_rd; a = n_ad;
    pulse_run();
    wait_st(b + 1, "ab_st_tmo");
    cyc(5);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_ad(a + 1, "ab_tmo");
    chk("ab_starts", n_start - b, 1);
    chk("ab_rds", n_rd - r, 1);
    chk("ab_ad_lat", ad_cyc - done_cyc, 2);
    chk("ab_cycles", layer_cycles, DLAT);

    // run and abort together in IDLE: run wins
    b = n_start; a = n_ad;
    run = 1'b1;
    abort = 1'b1;
    cyc(1);
    run = 1'b0;
    abort = 1'b0;
    wait_ad(a + 1, "ra_tmo");
    chk("ra_starts", n_start - b, 3);

    // done held high throughout
    done_hold = 1'b1;
    cyc(5);
    chk("hd_idle", busy, 0);
    b = n_start; r = n_rd; a = n_ad;
    pulse_run();
    wait_ad(a + 1, "hd_tmo");
    chk("hd_starts", n_start - b, 3);
    chk("hd_rds", n_rd - r, 3);
    chk("hd_lay3", lay_log[b+2], 3);
    chk("hd_cycles", layer_cycles, 1);
    done_hold = 1'b0;
    cyc(3);

    // run held high across a whole run
    b = n_start; r = n_rd; a = n_ad;
    run = 1'b1;
    wait_ad(a + 1, "rh_tmo");
    chk("rh_starts", n_start - b, 3);
    chk("rh_rds", n_rd - r, 3);
    cyc(1);
    chk("rh_refetch", bus.cfg_rd_en, 1);
    chk("rh_layer", count_layer, 1);
    run = 1'b0;
    wait_ad(a + 2, "rh_tmo2");
    chk("rh_starts2", n_start - b, 6);

    // Reset during WAIT of layer 2
    b = n_start;
    pulse_run();
    wait_st(b + 2, "rs_st_tmo");
    cyc(4);
    a = n_ad;
    rst = 1'b1;
    cyc(1);
    chk("rs_busy", busy, 0);
    chk("rs_layer", count_layer, 0);
    chk("rs_waddr", start_write_addr, 0);
    chk("rs_raddr", start_read_addr, 0);
    chk("rs_ifm", ifm_size, 0);
    chk("rs_cycles", layer_cycles, 0);
    rst = 1'b0;
    cyc(40);
    chk("rs_no_ad", n_ad - a, 0);
    chk("rs_stay_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 10: layers per network run; legal range 1..15.
REQ-002 Parameter OFM_RAM_SIZE, default 2378675: sets AW = $clog2(OFM_RAM_SIZE), which is 22 at the default.
REQ-003 Parameter CFG_WIDTH, default 64: width of one config-table word.
REQ-004 clk  in  1  single clock; all logic SHALL be on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 run  in  1  request to start a network run; sampled only in IDLE.
REQ-007 abort  in  1  request to stop the run after the current layer.
REQ-008 cfg_rd_en  out  1  config-table read strobe.
REQ-009 cfg_addr  out  4  config-table index, equal to count_layer-1.
REQ-010 cfg_data  in  CFG_WIDTH  config word; valid 1 cycle after cfg_rd_en.
REQ-011 start  out  1  one-cycle pulse that launches the accelerator on one layer.
REQ-012 done  in  1  accelerator layer-complete; may be a pulse or a level.
REQ-013 count_layer  out  4  current layer, 1-based.
REQ-014 Per-layer config outputs SHALL be: ifm_size out 9; ifm_channel out 11; kernel_size out 2; num_filter out 11; maxpool_mode out 1; maxpool_stride out 2; upsample_mode out 1.
REQ-015 Address outputs SHALL be: start_read_addr out AW; start_write_addr out AW.
REQ-016 Status outputs SHALL be: busy out 1 (high when not in IDLE); all_done out 1 (pulse at end of run); err out 1 (sticky config-error flag); err_layer out 4 (layer that failed validation).
REQ-017 layer_cycles  out  32  cycle count of the most recently completed layer.

Function
REQ-018 cfg_data fields, LSB first: ifm_size[8:0], ifm_channel[19:9], kernel_size[21:20], num_filter[32:22], maxpool_mode[33], maxpool_stride[35:34], upsample_mode[36], write_addr[58:37]; bits [63:59] reserved and ignored.
REQ-019 The FSM SHALL have states IDLE, FETCH, LATCH, CHECK, START, WAIT, NEXT, FINISH, ERROR.
REQ-020 IDLE -> FETCH when run=1; entering FETCH from IDLE SHALL set count_layer=1, start_read_addr=0 and clear err.
REQ-021 FETCH: cfg_rd_en=1 for exactly one cycle; cfg_addr=count_layer-1; next state LATCH.
REQ-022 LATCH: all config outputs and start_write_addr SHALL register from cfg_data; next state CHECK.
REQ-023 CHECK validity rule: kernel_size is 1 or 3, ifm_size >= kernel_size, ifm_channel != 0, num_filter != 0, and maxpool_stride is 1 or 2 when maxpool_mode=1.
REQ-024 CHECK transitions: valid -> START; invalid -> ERROR with err=1 and err_layer=count_layer.
REQ-025 START: start=1 for exactly one cycle; layer_cycles counter SHALL clear; next state WAIT.
REQ-026 WAIT: the cycle counter SHALL increment each cycle, saturating at 32'hFFFFFFFF.
REQ-027 WAIT exits to NEXT on the first cycle done=1; done SHALL be ignored in every other state, including the START cycle.
REQ-028 NEXT: layer_cycles SHALL register the counter value; start_read_addr SHALL take the current start_write_addr (ping-pong chaining).
REQ-029 NEXT transitions: if count_layer==NUM_LAYERS or abort is latched -> FINISH; else count_layer+1 -> FETCH.
REQ-030 FINISH: all_done=1 for one cycle, then IDLE.
REQ-031 ERROR: busy=1; the FSM SHALL stay in ERROR until run=1, which clears err and goes to IDLE; no start pulse SHALL be issued from ERROR.
REQ-032 Config outputs SHALL hold stable from LATCH until the next LATCH, including through WAIT, FINISH and IDLE.
REQ-033 Latency: run sampled at cycle t -> cfg_rd_en at t+1 -> start at t+4.
REQ-034 done=1 at cycle d -> next cfg_rd_en at d+2, or all_done at d+2 on the last layer.
REQ-035 abort SHALL latch whenever busy=1; the latch SHALL clear on entering IDLE.
REQ-036 abort in FETCH, LATCH or CHECK SHALL go directly to FINISH with no start pulse.
REQ-037 abort in START or WAIT SHALL take effect at NEXT, so the running layer always completes.
REQ-038 run while busy=1, outside ERROR, SHALL be ignored.
REQ-039 If run and abort are high together in IDLE, run SHALL win and the abort latch SHALL stay clear.
REQ-040 Held-high done: after leaving WAIT, done SHALL not be re-sampled until WAIT is re-entered.

Reset
REQ-041 rst=1 SHALL force IDLE on the next edge and clear all outputs to 0: start, cfg_rd_en, cfg_addr, count_layer, all config outputs, both addresses, busy, all_done, err, err_layer, layer_cycles, and the abort latch.
REQ-042 rst SHALL take priority over all inputs; reset mid-WAIT SHALL abandon the layer with no all_done pulse.

Verification
REQ-043 NUM_LAYERS=3 with valid table, done pulsed 20 cycles after each start -> 3 start pulses; count_layer 1,2,3; start_read_addr 0, W1, W2; layer_cycles=20; one all_done.
REQ-044 Layer-2 word with kernel_size=2 -> err=1, err_layer=2, exactly 1 start pulse; then run=1 -> IDLE with err=0.
REQ-045 abort asserted mid-WAIT of layer 1 (of 10) -> layer 1 completes, no FETCH for layer 2, all_done pulses 2 cycles after done.
REQ-046 done held high permanently from cycle 0 -> ignored in IDLE; each layer advances exactly once, with one start per WAIT.
REQ-047 rst asserted during WAIT of layer 5 -> next cycle: busy=0, count_layer=0, start_write_addr=0, no all_done.
REQ-048 run held high across a whole run -> single run only; re-entry FETCH occurs only after FINISH -> IDLE.
